// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and parameter checks for the elastic pipeline register.
// Optional skid buffer is enabled by defining PIPE_STAGE_REG_SKID_EN.
package pipe_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 8;
  localparam int unsigned PIPE_MAX_WIDTH = 256;

  function automatic bit pipe_params_ok(input int unsigned width, input int unsigned depth);
    return (width >= 1) && (width <= PIPE_MAX_WIDTH) &&
           (depth >= 1) && (depth <= PIPE_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle for pipe_stage_reg.
// The block itself attaches through the slave modport; PIPE_STAGE_REG_SKID_EN does not change the bundle.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
) ();
  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg_stage.sv
// One valid/data register pair of the elastic chain (also reused as the skid entry
// when PIPE_STAGE_REG_SKID_EN is defined).
module pipe_stage #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data is only written on load so a squashed or drained stage keeps its last payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RST_VAL;
    end else if (flush) begin
      v <= 1'b0;
    end else if (load) begin
      v <= 1'b1;
      d <= din;
    end else if (clear) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage pipeline register with bubble collapsing, flush and occupancy.
// Define PIPE_STAGE_REG_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_reg_if.slave   bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  if (!pipe_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("pipe_stage_reg: WIDTH or DEPTH out of range");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] up_d  [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             acc;
  logic             leave;
  logic [OCC_W-1:0] occ;

  assign acc   = bus.in_valid && bus.in_ready;
  assign leave = v[DEPTH-1] && bus.out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             s_v;
  logic [WIDTH-1:0] s_d;

  // Skid parks an accepted beat stage 0 cannot take; it always drains ahead of new input,
  // and in_ready is blocked while it is occupied so at most one beat can be waiting.
  pipe_stage #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .load  (acc && !rdy[0]),
    .clear (s_v && rdy[0]),
    .din   (bus.in_data),
    .v     (s_v),
    .d     (s_d)
  );

  assign src_v        = s_v || acc;
  assign src_d        = s_v ? s_d : bus.in_data;
  assign bus.in_ready = !s_v && !bus.flush;
`else
  assign src_v        = bus.in_valid;
  assign src_d        = bus.in_data;
  assign bus.in_ready = rdy[0] && !bus.flush;
`endif

  always_comb begin
    rdy   = '0;
    load  = '0;
    clear = '0;
    rdy[DEPTH] = bus.out_ready;
    // Ready ripples from the output back toward stage 0.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy[DEPTH-1-k] = !v[DEPTH-1-k] || rdy[DEPTH-k];
    end
    up_d[0]  = src_d;
    load[0]  = src_v && rdy[0];
    clear[0] = v[0] && rdy[1];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_d[i]  = d[i-1];
      load[i]  = v[i-1] && rdy[i];
      clear[i] = v[i] && rdy[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .load  (load[i]),
      .clear (clear[i]),
      .din   (up_d[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  // Internal shifts are occupancy-neutral, so only entry and exit move the count.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(acc) - OCC_W'(leave);
    end
  end

  assign bus.occupancy = occ;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-of-beats reference model.
// Covers both builds; with PIPE_STAGE_REG_SKID_EN the chain is DEPTH=2 plus skid.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 3;
`endif
  localparam logic [7:0] RSTV = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

  pipe_stage_reg #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(RSTV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: ordered beats (oldest first), each with its stage position; -1 is the skid entry.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } beat_t;
  beat_t q[$];

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Oldest beat exits if at the end and downstream ready; every other beat advances one slot if free.
  function automatic void shift_queue(input bit ordy);
    if (q.size() > 0 && q[0].pos == int'(DEPTH) - 1 && ordy) void'(q.pop_front());
    for (int i = 0; i < q.size(); i++) begin
      int lim;
      lim = (i == 0) ? int'(DEPTH) - 1 : q[i-1].pos - 1;
      if (q[i].pos < lim) q[i].pos++;
    end
  endfunction

  function automatic bit head_free();
    return (q.size() == 0) || (q[q.size()-1].pos > 0);
  endfunction

  function automatic bit exp_ir();
`ifdef PIPE_STAGE_REG_SKID_EN
    return !bus.flush && !(q.size() > 0 && q[q.size()-1].pos == -1);
`else
    beat_t save[$];
    bit    f;
    save = q;
    shift_queue(bus.out_ready);
    f = head_free();
    q = save;
    return !bus.flush && f;
`endif
  endfunction

  function automatic bit exp_ov();
    return (q.size() > 0) && (q[0].pos == int'(DEPTH) - 1);
  endfunction

  function automatic void model_edge(input bit ir);
    beat_t b;
    bit    a;
    if (rst) begin
      q.delete();
      return;
    end
    a = bus.in_valid && ir;
    shift_queue(bus.out_ready);
    if (bus.flush) begin
      q.delete();
      return;
    end
    if (a) begin
      b.data = bus.in_data;
      b.pos  = head_free() ? 0 : -1;
      q.push_back(b);
    end
  endfunction

  task automatic drive(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit ir;
    @(negedge clk);
    ir = exp_ir();
    chk("in_ready", 32'(bus.in_ready), 32'(ir));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov()));
    if (exp_ov()) chk("out_data", 32'(bus.out_data), 32'(q[0].data));
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
    if (bus.in_valid && bus.in_ready) n_acc++;
    @(posedge clk);
    model_edge(ir);
    #1;
  endtask

  initial begin
    int acc0;
    drive(0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'(RSTV));
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Streaming at full throughput
    for (int k = 1; k <= 16; k++) begin
      drive(1, 8'(k), 1, 0);
      cycle();
      if (k == int'(DEPTH) - 1) chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      if (k == int'(DEPTH)) begin
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h01);
      end
    end
    chk("stream_occ", 32'(bus.occupancy), 32'(DEPTH));
    repeat (5) begin drive(0, 8'h00, 1, 0); cycle(); end
    chk("drain_occ", 32'(bus.occupancy), 32'd0);

    // Stall with three beats held
    drive(1, 8'h11, 0, 0); cycle();
    drive(1, 8'h22, 0, 0); cycle();
    drive(1, 8'h33, 0, 0); cycle();
    repeat (2) begin drive(1, 8'h44, 0, 0); cycle(); end
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_occ", 32'(bus.occupancy), 32'd3);
    chk("stall_data", 32'(bus.out_data), 32'h11);
    repeat (5) begin drive(0, 8'h00, 1, 0); cycle(); end

    // Bubble collapse behind a stalled output beat
    drive(1, 8'h55, 0, 0); cycle();
    repeat (DEPTH - 1) begin drive(0, 8'h00, 0, 0); cycle(); end
    chk("bub_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1, 8'h66, 0, 0); cycle();
    drive(1, 8'h77, 0, 0); cycle();
    chk("bub_occ", 32'(bus.occupancy), 32'd3);
    repeat (5) begin drive(0, 8'h00, 1, 0); cycle(); end

    // Flush with two beats held and an input beat offered
    drive(1, 8'h88, 0, 0); cycle();
    drive(1, 8'h99, 0, 0); cycle();
    chk("pre_flush_occ", 32'(bus.occupancy), 32'd2);
    drive(1, 8'hAA, 0, 1); cycle();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_occ", 32'(bus.occupancy), 32'd0);
    drive(0, 8'h00, 0, 0); cycle();
    chk("flush_no_accept", 32'(bus.occupancy), 32'd0);

    // Reset in mid-stream
    repeat (3) begin drive(1, 8'($urandom), 0, 0); cycle(); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'(RSTV));
    chk("mid_rst_occ", 32'(bus.occupancy), 32'd0);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Skid capacity: DEPTH+1 beats accepted against a stalled output
    acc0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'(8'hC1 + k), 0, 0);
      cycle();
      if (k == 1) chk("skid_ready_hi", 32'(bus.in_ready), 32'd1);
      if (k == 2) chk("skid_ready_lo", 32'(bus.in_ready), 32'd0);
    end
    chk("skid_accepted", 32'(n_acc - acc0), 32'd3);
    repeat (5) begin drive(0, 8'h00, 1, 0); cycle(); end
`else
    acc0 = n_acc;
`endif

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    repeat (6) begin drive(0, 8'h00, 1, 0); cycle(); end
    chk("final_occ", 32'(bus.occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register: a chain of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake, per-stage bubble collapsing, a synchronous flush and an occupancy count. It generalises our single-bit clocked register into the standard inter-stage register between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It supports stalls (out_ready low) and squashes (flush on branch mispredict or exception).

## Interface
- WIDTH, 32, payload width in bits (1..256)
- DEPTH, 1, number of register stages (1..8)
- RST_VAL, 0, value loaded into every stage's data register on reset (WIDTH bits)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  squash all held beats
- in_valid  input  1  upstream beat present
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  block accepts a beat this cycle
- out_valid  output  1  stage DEPTH-1 holds a beat
- out_data  output  WIDTH  payload of stage DEPTH-1
- out_ready  input  1  downstream accepts a beat this cycle
- occupancy  output  $clog2(DEPTH+2)  number of valid beats held, including the skid entry when enabled

## Operation
- Stage i state: v[i] (1 bit) and d[i] (WIDTH bits). Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data.
- Stage i ready: rdy[i] = !v[i] || rdy[i+1]. rdy[DEPTH] is out_ready. in_ready is rdy[0] && !flush.
- Transfer into stage i when the upstream valid is high and rdy[i] is high. Upstream valid is in_valid for stage 0 and v[i-1] otherwise.
  - On transfer: d[i] loads the upstream data and v[i] is set.
  - When stage i empties with no new beat arriving, v[i] clears and d[i] holds its value.
- Bubbles collapse: an empty stage accepts a beat even while downstream stalls.
- Flush: every v[i] clears on the next edge. d[i] holds. An in_valid beat presented in that cycle is not accepted, because in_ready is 0. out_valid may be high during the flush cycle and the downstream handshake completes normally.
- Occupancy equals the sum of the v[i] (plus the skid valid when enabled). It is a registered value, updated in the same edge as the v[i].
- Reset: all v[i] = 0, all d[i] = RST_VAL, out_valid = 0, out_data = RST_VAL, occupancy = 0, in_ready = 1 after reset.
- Priority, per edge: rst, then flush, then handshake.

## Timing
- Latency: a beat accepted at edge N into an empty chain is visible on out_valid/out_data after edge N+DEPTH-1. That is DEPTH register delays from in_data to out_data.
- Throughput: one beat per cycle while out_ready stays high.
- Full condition: with all v[i] set and out_ready = 0, in_ready = 0. Data is held stable and out_valid stays high until out_ready is asserted.
- Simultaneous events, all stages full:
  - With out_ready = 1 and in_valid = 1: one beat leaves, all stages shift, one beat enters, and occupancy is unchanged.
- in_ready has a combinational path from out_ready through the chain. The exception is when PIPE_STAGE_REG_SKID_EN is defined.
- rst asserted mid-stream: all beats are lost at that edge, and the outputs take their reset values.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined:
  - A one-entry skid buffer sits in front of stage 0 and capacity becomes DEPTH+1.
  - in_ready is a register: it equals "skid empty" as of the previous edge. This gives no combinational path from out_ready to in_ready.
  - A beat accepted while stage 0 cannot take it is parked in the skid entry. The skid entry drains into stage 0 before any new input.
  - Flush clears the skid valid as well.
  - Latency on an empty chain is unchanged, because the skid is bypassed when stage 0 is ready.
- PIPE_STAGE_REG_SKID_EN undefined: no skid buffer, and in_ready behaves as described in Operation.

## Structure
- Shared package pipe_pkg: PIPE_MAX_DEPTH = 8 and PIPE_MAX_WIDTH = 256 constants, plus a parameter range-check function used by elaboration-time assertions.
- Sub-module pipe_stage: one v/d register pair with load/clear/flush logic. It is instantiated DEPTH times in a generate loop.
- The skid entry is a separate instance of pipe_stage, guarded by the macro.

## Test plan
- Reset, WIDTH=8, DEPTH=3, RST_VAL=8'hA5: assert rst for 2 cycles. Expect out_valid=0, out_data=8'hA5, occupancy=0, and in_ready=1 after release.
- Stream 0x01..0x10 with out_ready=1, DEPTH=3: first out_valid after 3 edges, then one beat per cycle in order, with occupancy steady at 3.
- Stall: fill DEPTH=3 with 0x11, 0x22, 0x33 and hold out_ready=0. Expect in_ready=0, occupancy=3, and out_data=0x11 stable. Release out_ready: the beats drain in order with no duplicates.
- Bubble collapse: only the output stage is valid and out_ready=0. Expect in_ready=1 and two more beats accepted, giving occupancy=3.
- Flush: flush for one cycle while occupancy=2 and in_valid=1. Next cycle out_valid=0 and occupancy=0; the input beat was not accepted.
- With PIPE_STAGE_REG_SKID_EN, DEPTH=2: full chain with out_ready=0. Exactly 3 beats are accepted, in_ready falls one cycle after the skid fills, and all 3 beats exit in order.
